id_ex_stage: RTL and testbench

Decode-to-execute pipeline register of the 5-stage RISC-V core, with load-use hazard detection, bubble insertion and branch flush. It registers decoded operands and control and drives the execute stage. Its registered `ex_ALUOp`, `ex_Funct3` and `ex_Funct7` are the direct inputs of the ALU controller. It also produces the `stall` signal that freezes the PC and the IF/ID register.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, detects
// load-use hazards, inserts bubbles on hazard or flush, and counts them.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_PC,
  input  logic [DATA_W-1:0] id_RD1,
  input  logic [DATA_W-1:0] id_RD2,
  input  logic [DATA_W-1:0] id_Imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [2:0]        id_Funct3,
  input  logic [6:0]        id_Funct7,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_ALUSrc,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_Branch,
  input  logic              id_Jump,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_PC,
  output logic [DATA_W-1:0] ex_RD1,
  output logic [DATA_W-1:0] ex_RD2,
  output logic [DATA_W-1:0] ex_Imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_Funct3,
  output logic [6:0]        ex_Funct7,
  output logic [1:0]        ex_ALUOp,
  output logic              ex_ALUSrc,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_Branch,
  output logic              ex_Jump,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic load_use;
  logic bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = id_valid & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));
  // A flushed slot is discarded, so it never needs to hold upstream.
  assign stall  = load_use & ~flush;
  assign bubble = flush | load_use;

  // ID -> EX boundary; a bubble is an all-zero slot, which decodes as ADD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_PC       <= '0;
      ex_RD1      <= '0;
      ex_RD2      <= '0;
      ex_Imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_Funct3   <= '0;
      ex_Funct7   <= '0;
      ex_ALUOp    <= '0;
      ex_ALUSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_Jump     <= 1'b0;
      bubble_cnt  <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_PC       <= '0;
      ex_RD1      <= '0;
      ex_RD2      <= '0;
      ex_Imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_Funct3   <= '0;
      ex_Funct7   <= '0;
      ex_ALUOp    <= '0;
      ex_ALUSrc   <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_Jump     <= 1'b0;
      bubble_cnt  <= sat_inc(bubble_cnt);
    end else begin
      ex_valid    <= id_valid;
      ex_PC       <= id_PC;
      ex_RD1      <= id_RD1;
      ex_RD2      <= id_RD2;
      ex_Imm      <= id_Imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_Funct3   <= id_Funct3;
      ex_Funct7   <= id_Funct7;
      ex_ALUOp    <= id_ALUOp;
      ex_ALUSrc   <= id_ALUSrc;
      ex_MemRead  <= id_MemRead;
      ex_MemtoReg <= id_MemtoReg;
      // Invalid slots must never commit or redirect.
      ex_MemWrite <= id_MemWrite & id_valid;
      ex_RegWrite <= id_RegWrite & id_valid;
      ex_Branch   <= id_Branch & id_valid;
      ex_Jump     <= id_Jump & id_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/saturation/flush
// sequences, and randomized traffic against a slot-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  aluop;
    logic        alusrc, memread, memwrite, regwrite, memtoreg, branch, jump;
  } slot_t;

  typedef struct {
    slot_t      id;
    bit         u1, u2, fl;
    bit         e_stall;
    logic [4:0] e_rd;
    logic [1:0] e_aluop;
    bit         e_valid, e_rw;
    logic [3:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  slot_t id_s = '0;
  logic u1 = 1'b0, u2 = 1'b0, flush = 1'b0;

  logic        ex_valid, ex_ALUSrc, ex_MemRead, ex_MemWrite, ex_RegWrite;
  logic        ex_MemtoReg, ex_Branch, ex_Jump, stall;
  logic [31:0] ex_PC, ex_RD1, ex_RD2, ex_Imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_Funct3;
  logic [6:0]  ex_Funct7;
  logic [1:0]  ex_ALUOp;
  logic [3:0]  bubble_cnt;
  slot_t       dut_ex;

  slot_t ex_m;
  int    cnt_m;
  int    n_cmp = 0, n_fail = 0;
  vec_t  tbl[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_s.valid), .id_PC(id_s.pc),
    .id_RD1(id_s.rd1), .id_RD2(id_s.rd2), .id_Imm(id_s.imm),
    .id_rs1(id_s.rs1), .id_rs2(id_s.rs2), .id_rd(id_s.rd),
    .id_uses_rs1(u1), .id_uses_rs2(u2), .id_Funct3(id_s.f3),
    .id_Funct7(id_s.f7), .id_ALUOp(id_s.aluop), .id_ALUSrc(id_s.alusrc),
    .id_MemRead(id_s.memread), .id_MemWrite(id_s.memwrite),
    .id_RegWrite(id_s.regwrite), .id_MemtoReg(id_s.memtoreg),
    .id_Branch(id_s.branch), .id_Jump(id_s.jump), .flush(flush),
    .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_RD1(ex_RD1), .ex_RD2(ex_RD2),
    .ex_Imm(ex_Imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_Funct3(ex_Funct3), .ex_Funct7(ex_Funct7), .ex_ALUOp(ex_ALUOp),
    .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .stall(stall),
    .bubble_cnt(bubble_cnt)
  );

  assign dut_ex = {ex_valid, ex_PC, ex_RD1, ex_RD2, ex_Imm, ex_rs1, ex_rs2,
                   ex_rd, ex_Funct3, ex_Funct7, ex_ALUOp, ex_ALUSrc,
                   ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg,
                   ex_Branch, ex_Jump};

  task automatic chk(input string nm, input int idx, input logic [162:0] a,
                     input logic [162:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, a, e);
    end
  endtask

  // Does the instruction in decode depend on a load sitting in EX?
  function automatic bit m_hazard();
    if (!(id_s.valid && ex_m.valid && ex_m.memread && ex_m.rd != 0)) return 0;
    return (u1 && id_s.rs1 == ex_m.rd) || (u2 && id_s.rs2 == ex_m.rd);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      ex_m = '0; cnt_m = 0;
    end else if (flush || m_hazard()) begin
      ex_m = '0;
      cnt_m = (cnt_m < 15) ? cnt_m + 1 : 15;
    end else begin
      ex_m = id_s;
      if (!id_s.valid) begin
        ex_m.regwrite = 0; ex_m.memwrite = 0; ex_m.branch = 0; ex_m.jump = 0;
      end
    end
    #1;
  endtask

  function automatic slot_t mk(bit v, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [1:0] op, bit mr, bit rw);
    slot_t s;
    s = '0;
    s.valid = v; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.aluop = op;
    s.memread = mr; s.regwrite = rw; s.alusrc = mr; s.memtoreg = mr;
    s.pc = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s.valid = ($urandom_range(0, 9) < 8);
    s.rs1 = 5'($urandom_range(0, 3));
    s.rs2 = 5'($urandom_range(0, 3));
    s.rd  = 5'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic add(slot_t id, bit a1, bit a2, bit fl, bit es, logic [4:0] rd,
                     logic [1:0] op, bit ev, bit erw, logic [3:0] ec);
    vec_t v;
    v.id = id; v.u1 = a1; v.u2 = a2; v.fl = fl; v.e_stall = es; v.e_rd = rd;
    v.e_aluop = op; v.e_valid = ev; v.e_rw = erw; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset held with random decode inputs.
    id_s = rnd_slot(); id_s.valid = 1; id_s.memread = 1; u1 = 1; u2 = 1;
    @(posedge clk); #1;
    do_reset();
    reset = 1'b0;
    id_s = rnd_slot();
    tick();
    chk("rst_ex", 0, dut_ex, '0);
    chk("rst_stall", 0, stall, 0);
    chk("rst_cnt", 0, bubble_cnt, 0);
    reset = 1'b1;

    // Directed vectors (rd, rs1, rs2, aluop, memread, regwrite).
    add(mk(1,3,1,2,2'b10,0,1), 1,1,0, 0, 3,2'b10,1,1, 0);  // ADD x3,x1,x2
    add(mk(1,5,1,0,2'b00,1,1), 1,0,0, 0, 5,2'b00,1,1, 0);  // LW x5
    add(mk(1,6,5,7,2'b10,0,1), 1,1,0, 1, 0,2'b00,0,0, 1);  // ADD x6,x5,x7
    add(mk(1,6,5,7,2'b10,0,1), 1,1,0, 0, 6,2'b10,1,1, 1);  //  held, captured
    add(mk(1,0,1,0,2'b00,1,1), 1,0,0, 0, 0,2'b00,1,1, 1);  // LW x0
    add(mk(1,6,0,0,2'b10,0,1), 1,1,0, 0, 6,2'b10,1,1, 1);  // consumer of x0
    add(mk(1,5,1,0,2'b00,1,1), 1,0,0, 0, 5,2'b00,1,1, 1);  // LW x5
    add(mk(1,6,5,5,2'b11,0,1), 0,0,0, 0, 6,2'b11,1,1, 1);  // LUI x6
    add(mk(1,5,1,0,2'b00,1,1), 1,0,0, 0, 5,2'b00,1,1, 1);  // LW x5
    add(mk(1,6,5,5,2'b10,0,1), 1,1,1, 0, 0,2'b00,0,0, 2);  // hazard + flush
    add(mk(0,9,1,2,2'b10,0,1), 1,1,0, 0, 9,2'b10,0,0, 2);  // invalid slot
    add(mk(1,5,1,0,2'b00,1,1), 1,0,0, 0, 5,2'b00,1,1, 2);  // LW x5
    add(mk(1,7,5,0,2'b00,1,1), 1,0,0, 1, 0,2'b00,0,0, 3);  // LW x7,(x5)
    add(mk(1,7,5,0,2'b00,1,1), 1,0,0, 0, 7,2'b00,1,1, 3);  //  held, captured
    add(mk(1,8,7,1,2'b10,0,1), 1,1,0, 1, 0,2'b00,0,0, 4);  // ADD x8,x7,x1
    add(mk(1,8,7,1,2'b10,0,1), 1,1,0, 0, 8,2'b10,1,1, 4);  //  held, captured
    foreach (tbl[i]) begin
      id_s = tbl[i].id; u1 = tbl[i].u1; u2 = tbl[i].u2; flush = tbl[i].fl;
      #1;
      chk("tbl_stall", i, stall, tbl[i].e_stall);
      tick();
      chk("tbl_rd", i, ex_rd, tbl[i].e_rd);
      chk("tbl_aluop", i, ex_ALUOp, tbl[i].e_aluop);
      chk("tbl_valid", i, ex_valid, tbl[i].e_valid);
      chk("tbl_regwrite", i, ex_RegWrite, tbl[i].e_rw);
      chk("tbl_cnt", i, bubble_cnt, tbl[i].e_cnt);
    end
    flush = 0;

    // Counter saturation under repeated flushes.
    do_reset();
    flush = 1;
    for (int i = 0; i < 20; i++) begin
      id_s = rnd_slot();
      tick();
      chk("sat_cnt", i, bubble_cnt, (i + 1 < 15) ? i + 1 : 15);
    end
    flush = 0;

    // Asynchronous reset in the middle of a load-use stall.
    do_reset();
    id_s = mk(1,5,1,0,2'b00,1,1); u1 = 1; u2 = 0;
    tick();
    id_s = mk(1,6,5,7,2'b10,0,1); u1 = 1; u2 = 1;
    #1;
    chk("async_pre_stall", 0, stall, 1);
    reset = 1'b0;
    #1;
    chk("async_stall", 0, stall, 0);
    chk("async_ex", 0, dut_ex, '0);
    chk("async_cnt", 0, bubble_cnt, 0);
    ex_m = '0; cnt_m = 0;
    #1;
    reset = 1'b1;
    id_s = mk(1,3,1,2,2'b10,0,1);
    tick();
    chk("post_rst_rd", 0, ex_rd, 3);
    chk("post_rst_rw", 0, ex_RegWrite, 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit exp_stall;
      if (!(m_hazard() && !flush)) begin
        id_s = rnd_slot();
        u1 = $urandom_range(0, 1);
        u2 = $urandom_range(0, 1);
        id_s.memread = ($urandom_range(0, 1) == 1);
      end
      flush = ($urandom_range(0, 9) == 0);
      #1;
      exp_stall = m_hazard() && !flush;
      chk("rnd_stall", i, stall, exp_stall);
      tick();
      chk("rnd_ex", i, dut_ex, ex_m);
      chk("rnd_cnt", i, bubble_cnt, cnt_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
